mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port 32-bit instruction/data BRAM between the RISC-V core's fetch stage and its load/store stage. Each cycle it grants at most one requester, drives the memory port, and routes the one-cycle-latency read data back to the requester that issued it. Data accesses have priority. A bounded-starvation guard keeps fetch progressing, so the PC shown on the PMOD debug pins keeps advancing.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width from the core.
- `MEM_AW`, 12: word-address width of the BRAM, giving 4096 words.
- `STARVE_MAX`, 4: maximum consecutive data grants while fetch waits. Legal range is 1..15.

Ports:
- `sysclk`  in  1: system clock, 125 MHz.
- `btn`  in  1: reset, synchronous, active-high.
- `i_req`  in  1: fetch request.
- `i_addr`  in  ADDR_W: fetch byte address.
- `i_gnt`  out  1: fetch accepted this cycle.
- `i_rvalid`  out  1: fetch data valid.
- `i_rdata`  out  32: fetch data.
- `d_req`  in  1: load/store request.
- `d_we`  in  1: 1 means store.
- `d_wstrb`  in  4: byte enables for a store.
- `d_addr`  in  ADDR_W: data byte address.
- `d_wdata`  in  32: store data.
- `d_gnt`  out  1: data access accepted this cycle.
- `d_rvalid`  out  1: data access complete. Asserted for loads and stores.
- `d_rdata`  out  32: load data.
- `mem_en`  out  1: BRAM enable.
- `mem_we`  out  4: BRAM byte write enables.
- `mem_addr`  out  MEM_AW: BRAM word address.
- `mem_wdata`  out  32: BRAM write data.
- `mem_rdata`  in  32: BRAM read data, valid one cycle after `mem_en`.

## Operation
- Request handshake:
  - A requester holds `req` and its address/data stable until it sees `gnt`.
  - `gnt` is combinational in the same cycle as the request.
  - A requester may issue back-to-back requests. A new request can coincide with the `rvalid` of the previous one.
- Arbitration, computed each cycle:
  - Rule 1: if `d_req` is asserted and the guard is not tripped, grant data.
  - Rule 2: otherwise, if `i_req` is asserted, grant fetch.
  - Rule 3: otherwise, idle.
- Memory drive on a grant:
  - `mem_en`=1.
  - `mem_addr` = selected `addr[MEM_AW+1:2]`. Low two bits and bits above `MEM_AW+1` are ignored.
  - Fetch grant: `mem_we` = 0.
  - Data grant: `mem_we` = `d_we ? d_wstrb : 0`. `mem_wdata` = `d_wdata`.
  - Idle: all memory outputs are 0.
- Owner register `own`, two bits:
  - Encodings: NONE, FETCH, DATA_RD, DATA_WR.
  - Loaded every cycle with the class of the current grant. Loaded with NONE when there is no grant.
- Response, in the cycle after a grant:
  - `own`=FETCH: `i_rvalid`=1, `i_rdata`=`mem_rdata`.
  - `own`=DATA_RD: `d_rvalid`=1, `d_rdata`=`mem_rdata`.
  - `own`=DATA_WR: `d_rvalid`=1, `d_rdata`=0.
  - Any `rdata` not selected by `own` is driven 0.
- Starvation counter `streak`, 4 bits:
  - Increments on a data grant while `i_req`=1, saturating at `STARVE_MAX`.
  - Clears on any fetch grant, and in any cycle with `i_req`=0.
  - The guard is tripped when `streak`==`STARVE_MAX` and `i_req`=1. Rule 1 is then skipped for that cycle, so fetch wins.
- Simultaneous events:
  - When both requests are present and the guard is untripped, `d_gnt`=1 and `i_gnt`=0.
  - A stall on one requester never blocks the response due to the other.

## Timing
- Grant-to-rvalid latency is exactly 1 cycle, for loads, stores and fetches alike.
- Throughput is one access per cycle.
- No combinational path exists from `mem_rdata` to any `gnt`.
- Reset (`btn`=1 at a rising edge), including mid-operation:
  - `own`=NONE and `streak`=0 at the next edge.
  - The in-flight response is dropped.
  - During reset, all `gnt`, `rvalid`, `mem_en` and `mem_we` outputs are forced to 0.
  - Arbitration resumes on the first cycle with `btn`=0.
- Reset values of outputs:
  - `i_rvalid`, `d_rvalid`, `i_rdata` and `d_rdata` are 0 at reset.
  - `i_gnt`, `d_gnt`, `mem_en` and `mem_we` are 0 while `btn` is held.

## Configuration
- Macro: `ARB_STARVE_GUARD_EN`.
- Defined: the `streak` counter and guard operate as described under Operation.
- Undefined:
  - `streak` is not built.
  - Data has strict priority.
  - Fetch is granted only in cycles with `d_req`=0.

## Test plan
- Single fetch:
  - Stimulus: `i_req`=1, `i_addr`=0x0000_0010, BRAM word 4 = 0x0000_0013.
  - Expected: `i_gnt`=1 and `mem_addr`=4 in the same cycle; `i_rvalid`=1 with `i_rdata`=0x13 in the next cycle.
- Store then load:
  - Stimulus: a store to 0x20 with `d_wstrb`=4'b0011 and `d_wdata`=0xAABB_CCDD over old word 0x1111_1111, then a load from 0x20.
  - Expected: `mem_we`=0011; `d_rvalid` asserts for the store with `d_rdata`=0; the load returns 0x1111_CCDD.
- Contention:
  - Stimulus: `i_req` and `d_req` both held for 10 cycles, guard enabled, `STARVE_MAX`=4.
  - Expected grant pattern is D D D D I D D D D I.
  - With the macro undefined, there are 10 data grants and 0 fetch grants.
- Back-to-back fetches:
  - Stimulus: addresses 0x0, 0x4, 0x8 on consecutive cycles.
  - Expected: three consecutive `i_rvalid` cycles, in address order.
- Reset mid-operation:
  - Stimulus: `btn`=1 in the cycle after a load grant.
  - Expected: `d_rvalid` stays 0; all outputs are 0; the first post-reset `i_req` is granted immediately.
- Address aliasing:
  - Stimulus: `i_addr`=0x0000_4003 with `MEM_AW`=12.
  - Expected: `mem_addr`=0x000.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 32-bit BRAM between instruction fetch and load/store, data first,
// with a one-cycle read return. Define ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_AW     = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic              sysclk,
    input  logic              btn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE    = 2'b00,
        OWN_FETCH   = 2'b01,
        OWN_DATA_RD = 2'b10,
        OWN_DATA_WR = 2'b11
    } own_e;

    own_e own_d, own_q;
    logic grant_i_s;
    logic grant_d_s;
    logic guard_trip_s;

    // Byte-offset and out-of-range address bits are deliberately ignored.
    logic unused_addr_s;
    assign unused_addr_s = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                             d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

    logic [3:0] streak_d, streak_q;

    // Guard trips once fetch has sat through STARVE_MAX consecutive data grants.
    always_comb begin
        guard_trip_s = (streak_q == STREAK_MAX) && i_req;
    end

    // Streak counts data grants taken while fetch is waiting.
    always_comb begin
        streak_d = streak_q;
        if (!i_req || grant_i_s) begin
            streak_d = 4'd0;
        end else if (grant_d_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge sysclk) begin
        if (btn) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    // Without the guard data has strict priority.
    always_comb begin
        guard_trip_s = 1'b0;
    end
`endif

    // Arbitration: data first unless the guard has tripped, nothing granted during reset.
    always_comb begin
        grant_d_s = 1'b0;
        grant_i_s = 1'b0;
        if (btn) begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end else if (d_req && !guard_trip_s) begin
            grant_d_s = 1'b1;
        end else if (i_req) begin
            grant_i_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
            grant_i_s = 1'b0;
        end
    end

    assign i_gnt = grant_i_s;
    assign d_gnt = grant_d_s;

    // Memory port drive and owner tag for the response cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        own_d     = OWN_NONE;
        if (grant_d_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_wstrb : 4'b0000;
            mem_addr  = d_addr[MEM_AW+1:2];
            mem_wdata = d_wdata;
            own_d     = d_we ? OWN_DATA_WR : OWN_DATA_RD;
        end else if (grant_i_s) begin
            mem_en    = 1'b1;
            mem_addr  = i_addr[MEM_AW+1:2];
            own_d     = OWN_FETCH;
        end else begin
            own_d     = OWN_NONE;
        end
    end

    // Owner register.
    always_ff @(posedge sysclk) begin
        if (btn) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    // Route read data to the owner; btn also masks a response already in flight.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'h0000_0000;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0000_0000;
        if (!btn) begin
            case (own_q)
                OWN_FETCH: begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end
                OWN_DATA_RD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                OWN_DATA_WR: begin
                    d_rvalid = 1'b1;
                end
                default: begin
                    i_rvalid = 1'b0;
                    d_rvalid = 1'b0;
                end
            endcase
        end else begin
            i_rvalid = 1'b0;
            d_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the driver predicts grants and responses from the
// arbitration rules and a reference memory; a separate monitor checks the returned data.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 32;
    localparam int MEM_AW     = 12;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 4096;

    logic              sysclk = 1'b0;
    logic              btn;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    logic [31:0] bram    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    resp_t       iq[$];
    resp_t       dq[$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          wait_cnt = 0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .sysclk(sysclk), .btn(btn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // BRAM environment: read-first, one-cycle latency, byte writes.
    always @(posedge sysclk) begin
        if (mem_en) begin
            mem_rdata <= bram[mem_addr];
            if (mem_we != 4'b0000) bram[mem_addr] <= merge(bram[mem_addr], mem_wdata, mem_we);
        end
    end

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        return ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bus cycle: drive, predict grant and memory drive, queue the expected response.
    task automatic step(input logic b, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [3:0] ds,
                        input logic [31:0] da, input logic [31:0] dw,
                        output logic exp_i, output logic exp_d);
        logic guard;
        int   w;
        @(negedge sysclk);
        btn = b; i_req = ir; i_addr = ia;
        d_req = dr; d_we = dwe; d_wstrb = ds; d_addr = da; d_wdata = dw;
        if (b) begin
            iq.delete();
            dq.delete();
        end
        #1;
`ifdef ARB_STARVE_GUARD_EN
        guard = ir && (wait_cnt >= STARVE_MAX);
`else
        guard = 1'b0;
`endif
        exp_d = !b && dr && !guard;
        exp_i = !b && ir && !exp_d;
        chk("d_gnt", 32'(d_gnt), 32'(exp_d));
        chk("i_gnt", 32'(i_gnt), 32'(exp_i));
        chk("mem_en", 32'(mem_en), 32'(exp_d || exp_i));
        if (exp_d) begin
            w = word_of(da);
            chk("d_mem_addr", 32'(mem_addr), 32'(w));
            chk("d_mem_we", 32'(mem_we), dwe ? 32'(ds) : 32'h0);
            chk("d_mem_wdata", mem_wdata, dw);
            if (dwe) begin
                for (int k = 0; k < 4; k++) if (ds[k]) ref_mem[w][8*k +: 8] = dw[8*k +: 8];
                dq.push_back('{due: cyc + 1, data: 32'h0});
            end else begin
                dq.push_back('{due: cyc + 1, data: ref_mem[w]});
            end
        end else if (exp_i) begin
            w = word_of(ia);
            chk("i_mem_addr", 32'(mem_addr), 32'(w));
            chk("i_mem_we", 32'(mem_we), 32'h0);
            iq.push_back('{due: cyc + 1, data: ref_mem[w]});
        end else begin
            chk("idle_mem_addr", 32'(mem_addr), 32'h0);
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_mem_wdata", mem_wdata, 32'h0);
        end
        if (b || !ir || exp_i) wait_cnt = 0;
        else if (exp_d) wait_cnt = wait_cnt + 1;
    endtask

    task automatic idle(input logic b);
        logic gi, gd;
        step(b, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
    endtask

    // Monitor: compare each response against the head of its queue.
    initial begin
        logic exp_v;
        forever begin
            @(negedge sysclk);
            #2;
            exp_v = (iq.size() > 0) && (iq[0].due == cyc);
            chk("i_rvalid", 32'(i_rvalid), 32'(exp_v));
            if (exp_v) begin
                chk("i_rdata", i_rdata, iq[0].data);
                void'(iq.pop_front());
            end else begin
                chk("i_rdata_idle", i_rdata, 32'h0);
            end
            while ((iq.size() > 0) && (iq[0].due <= cyc)) void'(iq.pop_front());
            exp_v = (dq.size() > 0) && (dq[0].due == cyc);
            chk("d_rvalid", 32'(d_rvalid), 32'(exp_v));
            if (exp_v) begin
                chk("d_rdata", d_rdata, dq[0].data);
                void'(dq.pop_front());
            end else begin
                chk("d_rdata_idle", d_rdata, 32'h0);
            end
            while ((dq.size() > 0) && (dq[0].due <= cyc)) void'(dq.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        gi, gd, ip, dp, dwe_r, rb;
        logic [3:0]  ds_r;
        logic [31:0] ia_r, da_r, dw_r;
        logic [9:0]  pattern, exp_pattern;

        for (int k = 0; k < DEPTH; k++) begin
            bram[k]    = $urandom();
            ref_mem[k] = bram[k];
        end
        bram[4] = 32'h0000_0013; ref_mem[4] = 32'h0000_0013;
        bram[8] = 32'h1111_1111; ref_mem[8] = 32'h1111_1111;
        mem_rdata = 32'h0;
        btn = 1'b1; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
        d_wstrb = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

        repeat (3) idle(1'b1);
        idle(1'b0);

        // Single fetch of word 4.
        step(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h4);
        idle(1'b0);

        // Partial store over 0x1111_1111, then load back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hAABB_CCDD, gi, gd);
        chk("store_mem_we", 32'(mem_we), 32'h3);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, gi, gd);
        idle(1'b0);

        // Back-to-back fetches.
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b1, 32'(4 * k), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
        idle(1'b0);

        // Address aliasing.
        step(1'b0, 1'b1, 32'h0000_4003, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("alias_mem_addr", 32'(mem_addr), 32'h0);
        idle(1'b0);

        // Contention: both held for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0, gi, gd);
            pattern[k] = d_gnt;
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_pattern = 10'b01111_01111;
`else
        exp_pattern = 10'b11111_11111;
`endif
        chk("contention_pattern", 32'(pattern), 32'(exp_pattern));
        idle(1'b0);

        // Reset in the response cycle of a load, with both requests present.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, gi, gd);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 4'hF, 32'h80, 32'h1234_5678, gi, gd);
        step(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, gi, gd);
        chk("post_reset_i_gnt", 32'(i_gnt), 32'h1);
        idle(1'b0);

        // Randomized traffic; requesters hold until granted.
        ip = 1'b0; dp = 1'b0; ia_r = 32'h0; da_r = 32'h0; dw_r = 32'h0; ds_r = 4'h0; dwe_r = 1'b0;
        for (int k = 0; k < 800; k++) begin
            if (!ip && ($urandom_range(0, 99) < 70)) begin
                ip = 1'b1; ia_r = rand_addr();
            end
            if (!dp && ($urandom_range(0, 99) < 55)) begin
                dp = 1'b1; dwe_r = 1'($urandom_range(0, 1)); ds_r = 4'($urandom());
                da_r = rand_addr(); dw_r = $urandom();
            end
            rb = ($urandom_range(0, 149) == 0);
            step(rb, ip, ia_r, dp, dwe_r, ds_r, da_r, dw_r, gi, gd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
        end
        idle(1'b0);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
